// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle shared by a FIFO and its UART consumer.
// master = FIFO (drives data/flag), slave = consumer (drives pop).
interface fifo_uart_tx_if;
  logic       Empty;
  logic [7:0] R_data;
  logic       R_en;

  modport master (
    output Empty,
    output R_data,
    input  R_en
  );

  modport slave (
    input  Empty,
    input  R_data,
    output R_en
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains an 8-bit FIFO.
// Pops one byte when idle and serialises it LSB first on tx.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_en,
  fifo_uart_tx_if.slave fifo,
  output logic          tx,
  output logic          busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              pop;
  logic              baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state: frame sequencing, baud/bit counting, shifting.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        pop    = tx_en & ~fifo.Empty;
        if (pop) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = fifo.R_data;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the state being entered, so tx is registered
  // yet changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Pop is suppressed while reset is held so no byte is lost to reset.
  assign fifo.R_en = pop & rst;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE) | fifo.R_en;

endmodule
